reorder_buffer_dual_commit: RTL
===============================

# reorder_buffer_dual_commit

Parametrised next-generation reorder buffer for the out-of-order core: in-order retirement of up to two instructions per cycle, count-based full/empty so all DEPTH entries are usable, same-cycle CDB bypass on dispatcher operand queries, and a one-cycle registered flush on branch mispredict. It sits between the Dispatcher (allocation and operand lookup), the CDB (results), the RegisterFile (commits), the LoadStoreBuffer (store release) and the Instruction Fetcher (redirect).

## Interface
- ADDR_WIDTH, 32, pc width
- REG_WIDTH, 5, architectural register index width; rd==0 means no writeback
- RoB_WIDTH, 4, index width; DEPTH = 1<<RoB_WIDTH
- NON_DEP, 1<<RoB_WIDTH, "no dependency" tag on the EX_RoB_WIDTH = RoB_WIDTH+1 query ports
- Sys_clk  in  1  single clock, rising edge
- Sys_rst  in  1  reset, asynchronous, active-high
- Sys_rdy  in  1  global enable; when low, all state holds and registered outputs hold
- DPRoB_en  in  1  allocate one entry at tail
- DPRoB_pc  in  ADDR_WIDTH  instruction pc
- DPRoB_type  in  2  0 OTHER, 1 BRANCH, 2 STORE
- DPRoB_rd  in  REG_WIDTH  destination register
- DPRoB_predict  in  1  predicted taken (BRANCH only)
- DPRoB_Qj, DPRoB_Qk  in  EX_RoB_WIDTH  operand tags to look up
- RoBDP_full  out  1  count==DEPTH (combinational)
- RoBDP_index  out  RoB_WIDTH  tail (combinational)
- RoBDP_Qj_ready, RoBDP_Qk_ready  out  1  operand available (combinational)
- RoBDP_Vj, RoBDP_Vk  out  32  operand value; 0 when tag==NON_DEP
- CDBRoB_RS_en / _index (RoB_WIDTH) / _value (32) / _next_pc (ADDR_WIDTH)  in  ALU/branch result port; for branches value[0] = taken, next_pc = correct target
- CDBRoB_LSB_en / _index / _value  in  load result or store-ready port
- RoBRF_en  out  2  per-slot commit valid (registered)
- RoBRF_rd  out  2*REG_WIDTH  slot s at [s*REG_WIDTH +: REG_WIDTH]
- RoBRF_value  out  64  slot s at [s*32 +: 32]
- RoBRF_index  out  2*RoB_WIDTH  committed entry indices
- RoBLSB_store_en  out  1  a STORE retired this cycle (registered pulse)
- RoBLSB_store_index  out  RoB_WIDTH  its entry index
- RoB_flush  out  1  one-cycle mispredict flush to every unit (registered)
- RoBIF_next_pc  out  ADDR_WIDTH  redirect target, valid with RoB_flush

## Operation
- State: per-entry busy, ready, type, rd, pc, predict, value, next_pc; head, tail (RoB_WIDTH, wrap mod DEPTH); count (RoB_WIDTH+1 bits).
- Dispatch: when DPRoB_en && !RoBDP_full, write entry at tail, busy=1, ready=0, tail+1. DPRoB_en while full is ignored with no state change.
- CDB: each enabled port sets ready=1 and writes value (RS port also writes next_pc). Both ports may target different entries in the same cycle.
- Query: ready = tag==NON_DEP || ready[tag] || (RS_en && RS_index==tag) || (LSB_en && LSB_index==tag). Value priority: RS bypass, then LSB bypass, then stored value.
- Commit slot 0: head busy && ready.
- Commit slot 1: only if slot 0 commits, head is not BRANCH, head+1 busy && ready, and not both entries are STORE.
- Per commit: clear busy and ready; head advances by the number committed.
- count_next = count + dispatch − commits.
- Mispredict: slot 0 is a BRANCH with value[0] != predict. It retires (RoBRF_en=0 for branches; branches never write rd). On that edge, clear all busy/ready, head=tail=count=0, RoB_flush<=1, RoBIF_next_pc<=next_pc[head].
- Correct branch retires normally with no flush.
- While RoB_flush==1, DPRoB_en and both CDB ports are ignored (squashed path).
- RoBRF_en slot is 1 only for committed OTHER entries; a committed STORE drives RoBLSB_store_en instead. RoBRF_rd=0 entries still assert RoBRF_en; RF discards writes to x0.

## Timing
- Reset (async): head=tail=count=0, all busy/ready=0; RoBRF_en=0, RoBRF_rd/value/index=0, RoBLSB_store_en=0, RoBLSB_store_index=0, RoB_flush=0, RoBIF_next_pc=0.
- Reset asserted mid-operation clears everything immediately, regardless of Sys_clk.
- Latencies:
  - CDB write at edge N → entry commit-eligible at N, RoBRF_en high after edge N+1 at earliest.
  - Dispatcher query sees a CDB result in the same cycle (bypass).
- Full is evaluated on pre-edge count: a dispatch in a cycle where count==DEPTH is rejected even if a commit frees an entry on the same edge.
- Empty (count==0): head not busy, so no commit.
- Wrap: index DEPTH−1 is followed by 0 for tail, head and head+1.
- Registered outputs deassert on the cycle after their condition disappears; RoB_flush is high for exactly one cycle.

## Test plan
- Reset mid-run with 5 busy entries → all outputs 0 immediately; RoBDP_index=0, RoBDP_full=0.
- Dispatch 16 OTHER entries (RoB_WIDTH=4) → RoBDP_full=1 after 16th; 17th dispatch ignored, RoBDP_index stays 0.
- Entries 0,1 ready with rd=3/5, values 0xA/0xB → single cycle with RoBRF_en=2'b11, rd={5,3}, values {0xB,0xA}; head=2.
- BRANCH at head, predict=1, CDB value=0, next_pc=0x100, younger entries ready → RoB_flush=1 for one cycle, RoBIF_next_pc=0x100, count=0, younger entries not committed.
- Two adjacent STOREs ready → committed on separate cycles; RoBLSB_store_en pulses twice with indices k, k+1.
- Query Qj=7 while CDBRoB_RS_en with index 7, value 0x55 in the same cycle → RoBDP_Qj_ready=1, RoBDP_Vj=0x55; Qj=NON_DEP → ready=1, Vj=0.

Source files
------------

// File: rtl/reorder_buffer_dual_commit.sv
// Reorder buffer with in-order dual retirement, CDB bypass on operand
// lookups and a registered one-cycle flush on branch mispredict.
module reorder_buffer_dual_commit #(
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int RoB_WIDTH  = 4,
   parameter int NON_DEP    = 1 << RoB_WIDTH
) (
   input  logic                     Sys_clk,
   input  logic                     Sys_rst,
   input  logic                     Sys_rdy,
   input  logic                     DPRoB_en,
   input  logic [ADDR_WIDTH-1:0]    DPRoB_pc,
   input  logic [1:0]               DPRoB_type,
   input  logic [REG_WIDTH-1:0]     DPRoB_rd,
   input  logic                     DPRoB_predict,
   input  logic [RoB_WIDTH:0]       DPRoB_Qj,
   input  logic [RoB_WIDTH:0]       DPRoB_Qk,
   output logic                     RoBDP_full,
   output logic [RoB_WIDTH-1:0]     RoBDP_index,
   output logic                     RoBDP_Qj_ready,
   output logic                     RoBDP_Qk_ready,
   output logic [31:0]              RoBDP_Vj,
   output logic [31:0]              RoBDP_Vk,
   input  logic                     CDBRoB_RS_en,
   input  logic [RoB_WIDTH-1:0]     CDBRoB_RS_index,
   input  logic [31:0]              CDBRoB_RS_value,
   input  logic [ADDR_WIDTH-1:0]    CDBRoB_RS_next_pc,
   input  logic                     CDBRoB_LSB_en,
   input  logic [RoB_WIDTH-1:0]     CDBRoB_LSB_index,
   input  logic [31:0]              CDBRoB_LSB_value,
   output logic [1:0]               RoBRF_en,
   output logic [2*REG_WIDTH-1:0]   RoBRF_rd,
   output logic [63:0]              RoBRF_value,
   output logic [2*RoB_WIDTH-1:0]   RoBRF_index,
   output logic                     RoBLSB_store_en,
   output logic [RoB_WIDTH-1:0]     RoBLSB_store_index,
   output logic                     RoB_flush,
   output logic [ADDR_WIDTH-1:0]    RoBIF_next_pc
);

   localparam int DEPTH = 1 << RoB_WIDTH;
   localparam int CW = RoB_WIDTH + 1;
   localparam logic [RoB_WIDTH:0] NDEP = CW'(NON_DEP);
   localparam logic [RoB_WIDTH:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      T_OTHER  = 2'd0,
      T_BRANCH = 2'd1,
      T_STORE  = 2'd2
   } rob_type_e;

   logic                  busy [DEPTH];
   logic                  rdy  [DEPTH];
   rob_type_e             typ  [DEPTH];
   logic [REG_WIDTH-1:0]  rd_q [DEPTH];
   logic                  pred [DEPTH];
   logic [31:0]           val  [DEPTH];
   logic [ADDR_WIDTH-1:0] npc  [DEPTH];

   logic [RoB_WIDTH-1:0] head, tail, head1;
   logic [RoB_WIDTH:0]   count, count_nx;
   logic                 c0, c1, mispred, disp, rs_ok, lsb_ok;
   logic                 ot0, ot1, st0, st1;
   logic [1:0]           n_commit;
   logic [REG_WIDTH-1:0] rd0, rd1;
   logic [31:0]          v0, v1;
   logic [RoB_WIDTH-1:0] idx0, idx1;

   assign head1 = head + 1'b1;
   assign RoBDP_full = (count == FULL_CNT);
   assign RoBDP_index = tail;

   // the squashed path is dropped while the flush is visible
   assign disp = DPRoB_en && !RoBDP_full && !RoB_flush;
   assign rs_ok = CDBRoB_RS_en && !RoB_flush;
   assign lsb_ok = CDBRoB_LSB_en && !RoB_flush;

   assign c0 = busy[head] && rdy[head];
   assign c1 = c0 && (typ[head] != T_BRANCH)
             && busy[head1] && rdy[head1]
             && !(typ[head] == T_STORE && typ[head1] == T_STORE);
   assign mispred = c0 && (typ[head] == T_BRANCH)
                  && (val[head][0] != pred[head]);

   assign ot0 = c0 && (typ[head] == T_OTHER);
   assign ot1 = c1 && (typ[head1] == T_OTHER);
   assign st0 = c0 && (typ[head] == T_STORE);
   assign st1 = c1 && (typ[head1] == T_STORE);

   assign n_commit = {1'b0, c0} + {1'b0, c1};
   assign count_nx = count + CW'(disp) - CW'(n_commit);

   assign rd0 = ot0 ? rd_q[head] : '0;
   assign rd1 = ot1 ? rd_q[head1] : '0;
   assign v0 = ot0 ? val[head] : '0;
   assign v1 = ot1 ? val[head1] : '0;
   assign idx0 = c0 ? head : '0;
   assign idx1 = c1 ? head1 : '0;

   logic [RoB_WIDTH:0] qtag [2];
   logic               q_rdy [2];
   logic [31:0]        q_val [2];

   assign qtag[0] = DPRoB_Qj;
   assign qtag[1] = DPRoB_Qk;
   assign RoBDP_Qj_ready = q_rdy[0];
   assign RoBDP_Qk_ready = q_rdy[1];
   assign RoBDP_Vj = q_val[0];
   assign RoBDP_Vk = q_val[1];

   always_comb begin
      for (int q = 0; q < 2; q++) begin
         q_rdy[q] = 1'b0;
         q_val[q] = '0;
         if (qtag[q] == NDEP) begin
            q_rdy[q] = 1'b1;
         end else if (rs_ok &&
            CDBRoB_RS_index == qtag[q][RoB_WIDTH-1:0]) begin
            q_rdy[q] = 1'b1;
            q_val[q] = CDBRoB_RS_value;
         end else if (lsb_ok &&
            CDBRoB_LSB_index == qtag[q][RoB_WIDTH-1:0]) begin
            q_rdy[q] = 1'b1;
            q_val[q] = CDBRoB_LSB_value;
         end else begin
            q_rdy[q] = rdy[qtag[q][RoB_WIDTH-1:0]];
            q_val[q] = val[qtag[q][RoB_WIDTH-1:0]];
         end
      end
   end

   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            busy[i] <= 1'b0;
            rdy[i] <= 1'b0;
         end
         RoBRF_en <= '0;
         RoBRF_rd <= '0;
         RoBRF_value <= '0;
         RoBRF_index <= '0;
         RoBLSB_store_en <= 1'b0;
         RoBLSB_store_index <= '0;
         RoB_flush <= 1'b0;
         RoBIF_next_pc <= '0;
      end else if (Sys_rdy) begin
         RoBRF_en <= {ot1, ot0};
         RoBRF_rd <= {rd1, rd0};
         RoBRF_value <= {v1, v0};
         RoBRF_index <= {idx1, idx0};
         RoBLSB_store_en <= st0 || st1;
         RoBLSB_store_index <= st0 ? head : (st1 ? head1 : '0);
         RoB_flush <= mispred;
         if (mispred) begin
            RoBIF_next_pc <= npc[head];
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               busy[i] <= 1'b0;
               rdy[i] <= 1'b0;
            end
         end else begin
            if (disp) begin
               busy[tail] <= 1'b1;
               rdy[tail] <= 1'b0;
               tail <= tail + 1'b1;
            end
            if (rs_ok) rdy[CDBRoB_RS_index] <= 1'b1;
            if (lsb_ok) rdy[CDBRoB_LSB_index] <= 1'b1;
            if (c0) begin
               busy[head] <= 1'b0;
               rdy[head] <= 1'b0;
            end
            if (c1) begin
               busy[head1] <= 1'b0;
               rdy[head1] <= 1'b0;
            end
            head <= head + RoB_WIDTH'(n_commit);
            count <= count_nx;
         end
      end
   end

   // payload needs no reset: it is only read behind busy/ready
   always_ff @(posedge Sys_clk) begin
      if (Sys_rdy) begin
         if (disp) begin
            typ[tail] <= rob_type_e'(DPRoB_type);
            rd_q[tail] <= DPRoB_rd;
            pred[tail] <= DPRoB_predict;
            val[tail] <= '0;
            npc[tail] <= DPRoB_pc;
         end
         if (rs_ok) begin
            val[CDBRoB_RS_index] <= CDBRoB_RS_value;
            npc[CDBRoB_RS_index] <= CDBRoB_RS_next_pc;
         end
         if (lsb_ok) val[CDBRoB_LSB_index] <= CDBRoB_LSB_value;
      end
   end

endmodule
